// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared types and width helper for the round-robin arbiter
// (the starvation monitor in rr_arbiter is enabled by RR_ARBITER_STARVE_MON_EN)
package rr_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: index of the lowest set bit of in_vec, with valid when any bit is set
module rr_prio_enc
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 16,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  in_vec,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = in_vec[i] ? IW'(i) : idx;
  end
  assign valid = |in_vec;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot/index grant and valid/ready handshake
// Define RR_ARBITER_STARVE_MON_EN to build the per-requester starvation counters behind starve_o.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned MAX_WAIT = 255,
  localparam int unsigned IW = idx_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic [NUM_REQ-1:0] starve_o
);
  state_t state, state_d;
  logic [IW-1:0] ptr, ptr_nxt, eff_ptr, hi_idx, raw_idx, win_idx;
  logic [NUM_REQ-1:0] cand, hi;
  logic accept, hi_vld, raw_vld, load;
  if (NUM_REQ < 2 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("rr_arbiter: NUM_REQ must be >= 2 and MAX_WAIT >= 1");
  end
  assign gnt_valid_o = (state == GRANT);
  assign accept = gnt_valid_o & gnt_ready_i;
  assign ptr_nxt = (gnt_idx_o == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  // On an accept edge the re-pick already uses the advanced pointer and skips the accepted requester.
  assign eff_ptr = accept ? ptr_nxt : ptr;
  assign cand = accept ? req_i & ~gnt_o : req_i;
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_REQ; i++) hi[i] = cand[i] & (i >= int'(eff_ptr));
  end
  rr_prio_enc #(.N(NUM_REQ)) u_hi (.in_vec(hi), .idx(hi_idx), .valid(hi_vld));
  rr_prio_enc #(.N(NUM_REQ)) u_raw (.in_vec(cand), .idx(raw_idx), .valid(raw_vld));
  assign win_idx = hi_vld ? hi_idx : raw_idx;
  always_comb begin
    load = raw_vld & ((state == IDLE) | accept);
    state_d = load ? GRANT : accept ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      gnt_o <= '0;
      gnt_idx_o <= '0;
    end else begin
      state <= state_d;
      ptr <= eff_ptr;
      gnt_o <= load ? NUM_REQ'(1) << win_idx : accept ? '0 : gnt_o;
      gnt_idx_o <= load ? win_idx : accept ? '0 : gnt_idx_o;
    end
  end
`ifdef RR_ARBITER_STARVE_MON_EN
  localparam int unsigned CW = idx_w(MAX_WAIT + 1);
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_mon
    logic [CW-1:0] cnt;
    logic held;
    // A requester holding the grant is being served, so its wait does not grow.
    assign held = gnt_valid_o && (gnt_idx_o == IW'(g));
    always_ff @(posedge clk_i) begin
      if (rst_i || !req_i[g] || (accept && held)) cnt <= '0;
      else if (!held && cnt != CW'(MAX_WAIT)) cnt <= cnt + 1'b1;
    end
    assign starve_o[g] = (cnt == CW'(MAX_WAIT));
  end
`else
  assign starve_o = '0;
`endif
endmodule
